// File: rtl/nic_wb_master_sequencer_pkg.sv
// Shared constants for the NIC WISHBONE master sequencer: bus geometry, CTI codes and
// FSM state encoding (kept as plain localparams so the slave side can reuse them).
package nic_wb_master_sequencer_pkg;

  localparam int unsigned BusAddressWidth = 32;
  localparam int unsigned BusDataWidth    = 32;
  localparam int unsigned Granularity     = 8;
  localparam int unsigned SelWidth        = BusDataWidth / Granularity;
  localparam int unsigned MaxBurstLenght  = 16;
  localparam int unsigned BytesPerBeat    = BusDataWidth / 8;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEnd     = 3'b111;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StXfer    = 3'd2;
  localparam logic [2:0] StBackoff = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  // Byte address of a given beat in an incrementing burst.
  function automatic logic [BusAddressWidth-1:0] beat_address(
    input logic [BusAddressWidth-1:0] base,
    input logic [BusAddressWidth-1:0] beat
  );
    return base + (beat << $clog2(BytesPerBeat));
  endfunction

endpackage

// File: rtl/nic_wb_master_sequencer_if.sv
// WISHBONE B3 bus bundle between the sequencer (master) and the slave fabric.
interface nic_wb_master_sequencer_if;
  import nic_wb_master_sequencer_pkg::*;

  logic                       cyc;
  logic                       stb;
  logic                       we;
  logic [BusAddressWidth-1:0] adr;
  logic [BusDataWidth-1:0]    dat_w;
  logic [SelWidth-1:0]        sel;
  logic [2:0]                 cti;
  logic [1:0]                 bte;
  logic                       ack;
  logic                       rty;
  logic                       err;
  logic [BusDataWidth-1:0]    dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel, cti, bte,
    input  ack, rty, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel, cti, bte,
    output ack, rty, err, dat_r
  );

endinterface

// File: rtl/nic_wb_master_sequencer_watchdog.sv
// Beat timeout watchdog: flags a strobe that has gone TimeoutCycles cycles without any termination.
module nic_wb_master_sequencer_watchdog #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic term_i,
  output logic timeout_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!stb_i || term_i) begin
      cnt_q <= '0;
    end else if (!timeout_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Fires on the TimeoutCycles-th silent strobe cycle, so stb is seen for exactly that many cycles.
  assign timeout_o = stb_i && !term_i && (cnt_q == 8'(TimeoutCycles - 1));

endmodule

// File: rtl/nic_wb_master_sequencer.sv
// Obtains the bus and runs single/incrementing-burst WISHBONE B3 cycles for the NIC message queue.
// Defining WB_TIMEOUT_EN adds a per-beat watchdog that terminates a silent beat as a bus error.
module nic_wb_master_sequencer
  import nic_wb_master_sequencer_pkg::*;
#(
  parameter int unsigned N_BITS_BURST_LENGHT = $clog2(MaxBurstLenght),
  parameter int unsigned RETRY_BACKOFF       = 4,
  parameter int unsigned TIMEOUT_CYCLES      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  // Message queue side
  input  logic                           r_bus_arbitration_i,
  input  logic [BusAddressWidth-1:0]     address_i,
  input  logic [BusDataWidth-1:0]        data_i,
  input  logic [SelWidth-1:0]            sel_i,
  input  logic                           transaction_type_i,
  input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
  output logic                           next_data_o,
  output logic                           message_transmitted_o,
  output logic                           retry_o,
  output logic                           error_o,
  // Arbiter side
  output logic                           bus_req_o,
  input  logic                           gnt_i,
  // WISHBONE side
  nic_wb_master_sequencer_if.master      wb,
  output logic [BusDataWidth-1:0]        rd_data_o,
  output logic                           rd_valid_o
);

  if (RETRY_BACKOFF < 1 || RETRY_BACKOFF > 255) begin : gen_bad_backoff
    $error("RETRY_BACKOFF must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  localparam logic [7:0] BackoffLast = 8'(RETRY_BACKOFF - 1);

  logic [2:0]                     state_q, state_d;
  logic [BusAddressWidth-1:0]     addr_q, addr_d;
  logic                           we_q, we_d;
  logic [N_BITS_BURST_LENGHT-1:0] len_q, len_d;
  logic [N_BITS_BURST_LENGHT-1:0] beat_q, beat_d;
  logic [7:0]                     backoff_q, backoff_d;
  logic                           next_data_q, next_data_d;
  logic                           done_q, done_d;
  logic                           retry_q, retry_d;
  logic                           error_q, error_d;
  logic                           rd_valid_q, rd_valid_d;
  logic [BusDataWidth-1:0]        rd_data_q, rd_data_d;
  logic                           in_xfer;
  logic                           last_beat;
  logic                           timeout;

  assign in_xfer   = (state_q == StXfer);
  assign last_beat = (beat_q == len_q);

`ifdef WB_TIMEOUT_EN
  nic_wb_master_sequencer_watchdog #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .stb_i    (in_xfer),
    .term_i   (wb.ack | wb.rty | wb.err),
    .timeout_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    len_d       = len_q;
    beat_d      = beat_q;
    backoff_d   = backoff_q;
    next_data_d = 1'b0;
    done_d      = 1'b0;
    retry_d     = 1'b0;
    error_d     = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;

    case (state_q)
      StIdle: begin
        if (r_bus_arbitration_i) begin
          addr_d  = address_i;
          we_d    = transaction_type_i;
          len_d   = burst_lenght_i;
          beat_d  = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (gnt_i) state_d = StXfer;
      end
      StXfer: begin
        // err (or watchdog) beats rty beats ack when they coincide.
        if (wb.err || timeout) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (wb.rty) begin
          retry_d   = 1'b1;
          beat_d    = '0;
          backoff_d = '0;
          state_d   = StBackoff;
        end else if (wb.ack) begin
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = wb.dat_r;
          end
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            next_data_d = 1'b1;
            beat_d      = beat_q + N_BITS_BURST_LENGHT'(1);
          end
        end
      end
      StBackoff: begin
        if (backoff_q == BackoffLast) begin
          state_d = StReq;
        end else begin
          backoff_d = backoff_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      backoff_q   <= '0;
      next_data_q <= 1'b0;
      done_q      <= 1'b0;
      retry_q     <= 1'b0;
      error_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      backoff_q   <= backoff_d;
      next_data_q <= next_data_d;
      done_q      <= done_d;
      retry_q     <= retry_d;
      error_q     <= error_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Bus controls decode straight from the state register so reset drops them asynchronously.
  assign bus_req_o = (state_q == StReq) || in_xfer;
  assign wb.cyc    = in_xfer;
  assign wb.stb    = in_xfer;
  assign wb.we     = in_xfer && we_q;
  assign wb.adr    = in_xfer ? beat_address(addr_q, BusAddressWidth'(beat_q)) : '0;
  assign wb.cti    = !in_xfer ? CtiClassic : (last_beat ? CtiEnd : CtiIncr);
  assign wb.bte    = 2'b00;
  assign wb.dat_w  = data_i;
  assign wb.sel    = sel_i;

  assign next_data_o           = next_data_q;
  assign message_transmitted_o = done_q;
  assign retry_o               = retry_q;
  assign error_o               = error_q;
  assign rd_valid_o            = rd_valid_q;
  assign rd_data_o             = rd_data_q;

endmodule
